// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and alignment rule for mem_access_unit.
package lsu_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return (size == 2'b11) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
   endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract with sign/zero extension, and lane merge for sub-word stores.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_old,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic [31:0] o_merged
);
   logic [4:0]  w_sh;
   logic [31:0] w_shifted;
   logic [31:0] w_mask;

   // halves are addressed by offset bit 1 only; bytes by both offset bits
   assign w_sh      = (i_size == SZ_HALF) ? {i_off[1], 4'b0000} : {i_off, 3'b000};
   assign w_shifted = i_word >> w_sh;
   assign w_mask    = ((i_size == SZ_BYTE) ? 32'h0000_00FF :
                       (i_size == SZ_HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF) << w_sh;

   assign o_rdata  = (i_size == SZ_BYTE) ? {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]} :
                     (i_size == SZ_HALF) ? {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]} : i_word;
   assign o_merged = (i_old & ~w_mask) | ((i_wdata << w_sh) & w_mask);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store initiator for a word-addressed data memory;
// sub-word stores are done as read-modify-write, misaligned requests never touch memory.
module mem_access_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_data_in,
   output logic              dm_write_enable,
   output logic              dm_read_enable,
   input  logic [31:0]       dm_data_out
);
   state_t            r_state, w_next;
   logic              r_write, r_signed, r_err;
   logic [1:0]        r_size, r_off;
   logic [31:0]       r_wdata, r_merge, r_rdata;
   logic [ADDR_W-1:0] r_addr;
   logic              w_mis;
   logic [31:0]       w_ext, w_merged;
   logic              w_unused;

   assign w_mis      = is_misaligned(req_size, req_addr[1:0]);
   assign w_unused   = ^req_addr[31:ADDR_W+2];
   assign dm_addr    = r_addr;
   assign resp_rdata = r_rdata;

   lsu_lane_align u_align (
      .i_word   (dm_data_out),
      .i_off    (r_off),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_old    (r_merge),
      .i_wdata  (r_wdata),
      .o_rdata  (w_ext),
      .o_merged (w_merged)
   );

   always_comb begin
      w_next          = r_state;
      req_ready       = 1'b0;
      resp_valid      = 1'b0;
      resp_err        = 1'b0;
      dm_read_enable  = 1'b0;
      dm_write_enable = 1'b0;
      dm_data_in      = 32'h0;
      case (r_state)
         IDLE: begin
            req_ready = ~rst;
            if (req_valid)
               w_next = w_mis ? RESP : (req_write && req_size == SZ_WORD) ? WRITE : READ;
         end
         READ: begin
            dm_read_enable = 1'b1;
            w_next         = r_write ? WRITE : RESP;
         end
         WRITE: begin
            dm_write_enable = 1'b1;
            dm_data_in      = w_merged;
            w_next          = RESP;
         end
         default: begin
            resp_valid = 1'b1;
            resp_err   = r_err;
            w_next     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_write  <= 1'b0;
         r_signed <= 1'b0;
         r_err    <= 1'b0;
         r_size   <= SZ_BYTE;
         r_off    <= 2'b00;
         r_wdata  <= 32'h0;
         r_merge  <= 32'h0;
         r_rdata  <= 32'h0;
         r_addr   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && req_valid) begin
            r_write  <= req_write;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata;
            r_err    <= w_mis;
            r_rdata  <= 32'h0;
            // a rejected request leaves the memory address bus untouched
            if (!w_mis) r_addr <= req_addr[ADDR_W+1:2];
         end
         if (r_state == READ) begin
            if (r_write) r_merge <= dm_data_out;
            else         r_rdata <= w_ext;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a byte-level memory model.
module tb_mem_access_unit;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]    req_size = 2'b00;
   logic [31:0]   req_addr = 32'h0, req_wdata = 32'h0;
   logic          req_ready, resp_valid, resp_err;
   logic [31:0]   resp_rdata, dm_data_in, dm_data_out;
   logic [AW-1:0] dm_addr;
   logic          dm_write_enable, dm_read_enable;

   logic [31:0] dm_mem [256];
   logic [31:0] ref_mem [256];
   logic        clr = 1'b0;
   int          n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk)
      if (clr) for (int i = 0; i < 256; i++) dm_mem[i] <= 32'h0;
      else if (dm_write_enable) dm_mem[dm_addr] <= dm_data_in;

   assign dm_data_out = dm_mem[dm_addr];

   mem_access_unit #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .dm_addr(dm_addr), .dm_data_in(dm_data_in), .dm_write_enable(dm_write_enable),
      .dm_read_enable(dm_read_enable), .dm_data_out(dm_data_out)
   );

   function automatic int ref_idx(input logic [31:0] a);
      return int'((a >> 2) & 32'd255);
   endfunction

   function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
      return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
   endfunction

   function automatic int ref_lat(input logic w, input logic [1:0] sz, input logic [31:0] a);
      return ref_err(sz, a) ? 1 : (w && sz != 2'd2) ? 3 : 2;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
      longint w, v, span;
      int     k;
      w = longint'(ref_mem[ref_idx(a)]);
      k = int'(a % 4);
      if (sz == 2'd2) return ref_mem[ref_idx(a)];
      span = (sz == 2'd0) ? 256 : 65536;
      v = (w >> (8 * k)) % span;
      if (sg && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int          k, nb;
      logic [31:0] w;
      k  = int'(a % 4);
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      w  = ref_mem[ref_idx(a)];
      for (int b = 0; b < nb; b++) w[8*(k+b) +: 8] = wd[8*b +: 8];
      ref_mem[ref_idx(a)] = w;
   endfunction

   function automatic int mem_diffs();
      int d = 0;
      for (int i = 0; i < 256; i++) if (dm_mem[i] !== ref_mem[i]) d++;
      return d;
   endfunction

   // one request; lat is the response cycle after accept (0 = no response), we_mask marks write-enable cycles
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic err, output logic [31:0] rd,
                        output int we_mask, output int n_re);
      int c = 0;
      lat = 0; err = 1'b0; rd = 32'h0; we_mask = 0; n_re = 0;
      @(negedge clk);
      while (!req_ready && c < 20) begin @(negedge clk); c++; end
      if (!req_ready) begin
         n_tests++; n_fail++;
         $display("FAIL ready_timeout: req_ready=%0b required 1", req_ready);
         return;
      end
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         @(negedge clk);
         if (dm_write_enable) we_mask |= 1 << i;
         if (dm_read_enable) n_re++;
         if (resp_valid) begin lat = i; err = resp_err; rd = resp_rdata; end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      rst = 1'b1; clr = 1'b1;
      @(posedge clk); @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({req_ready, resp_valid, resp_err, dm_write_enable, dm_read_enable} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 00000",
                  {req_ready, resp_valid, resp_err, dm_write_enable, dm_read_enable});
      end
      n_tests++;
      if ({dm_addr, dm_data_in, resp_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: dm_addr=%h dm_data_in=%h resp_rdata=%h required 0", dm_addr, dm_data_in, resp_rdata);
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready); end
   endtask

   task automatic test_word();
      int lat, wm, nr; logic err; logic [31:0] rd;
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, rd, wm, nr);
      ref_store(2'd2, 32'h10, 32'hDEADBEEF);
      n_tests++;
      if (lat != 2 || wm != 2 || nr != 0) begin
         n_fail++; $display("FAIL sw_timing: lat=%0d we_mask=%0h re=%0d required 2 2 0", lat, wm, nr);
      end
      n_tests++;
      if (dm_mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem: got %h required deadbeef", dm_mem[4]); end
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd, wm, nr);
      n_tests++;
      if (lat != 2 || rd !== 32'hDEADBEEF || err !== 1'b0 || nr != 1) begin
         n_fail++; $display("FAIL lw: lat=%0d rdata=%h err=%b re=%0d required 2 deadbeef 0 1", lat, rd, err, nr);
      end
   endtask

   task automatic test_sub_store();
      int lat, wm, nr; logic err; logic [31:0] rd;
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, lat, err, rd, wm, nr);
      ref_store(2'd2, 32'h10, 32'h11223344);
      issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h123456AA, lat, err, rd, wm, nr);
      ref_store(2'd0, 32'h12, 32'h123456AA);
      n_tests++;
      if (dm_mem[4] !== 32'h11AA3344) begin n_fail++; $display("FAIL sb_mem: got %h required 11aa3344", dm_mem[4]); end
      n_tests++;
      if (lat != 3 || wm != 4 || nr != 1 || rd !== 32'h0) begin
         n_fail++; $display("FAIL sb_timing: lat=%0d we_mask=%0h re=%0d rdata=%h required 3 4 1 0", lat, wm, nr, rd);
      end
   endtask

   task automatic test_loads();
      int lat, wm, nr; logic err; logic [31:0] rd;
      logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
      logic [31:0] ex [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFAABB, 32'h00008899};
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, lat, err, rd, wm, nr);
      ref_store(2'd2, 32'h10, 32'h8899AABB);
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, err, rd, wm, nr);
         n_tests++;
         if (lat != 2 || rd !== ex[i] || err !== 1'b0) begin
            n_fail++; $display("FAIL subload_%0d: lat=%0d rdata=%h err=%b required 2 %h 0", i, lat, rd, err, ex[i]);
         end
      end
   endtask

   task automatic test_errors();
      int lat, wm, nr; logic err; logic [31:0] rd;
      logic        w  [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
      logic [31:0] ad [3] = '{32'h11, 32'h22, 32'h10};
      for (int i = 0; i < 3; i++) begin
         issue(w[i], sz[i], 1'b1, ad[i], $urandom, lat, err, rd, wm, nr);
         n_tests++;
         if (lat != 1 || err !== 1'b1 || rd !== 32'h0 || wm != 0 || nr != 0) begin
            n_fail++;
            $display("FAIL err_%0d: lat=%0d err=%b rdata=%h we_mask=%0h re=%0d required 1 1 0 0 0", i, lat, err, rd, wm, nr);
         end
      end
      n_tests++;
      if (mem_diffs() != 0) begin n_fail++; $display("FAIL err_mem: %0d words differ required 0", mem_diffs()); end
   endtask

   task automatic test_wrap();
      int lat, wm, nr; logic err; logic [31:0] rd;
      issue(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, lat, err, rd, wm, nr);
      ref_store(2'd2, 32'h400, 32'hCAFEF00D);
      n_tests++;
      if (dm_mem[0] !== 32'hCAFEF00D || dm_addr !== 8'h00) begin
         n_fail++; $display("FAIL wrap: word0=%h dm_addr=%h required cafef00d 00", dm_mem[0], dm_addr);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  b = 8'($urandom);
      logic [31:0] exp_rd;
      int rdy_mask = 0, rv_mask = 0;
      logic [31:0] rd6 = 32'h0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h21; req_wdata = {24'hABCDEF, b};
      @(posedge clk);
      #1 req_write = 1'b0;
      ref_store(2'd0, 32'h21, {24'hABCDEF, b});
      exp_rd = ref_load(2'd0, 1'b0, 32'h21);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (req_ready) rdy_mask |= 1 << i;
         if (resp_valid) rv_mask |= 1 << i;
         if (i == 6) rd6 = resp_rdata;
      end
      req_valid = 1'b0;
      n_tests++;
      if (rdy_mask != 'h10) begin n_fail++; $display("FAIL b2b_ready: mask=%0h required 10", rdy_mask); end
      n_tests++;
      if (rv_mask != 'h48 || rd6 !== exp_rd) begin
         n_fail++; $display("FAIL b2b_resp: mask=%0h rdata=%h required 48 %h", rv_mask, rd6, exp_rd);
      end
   endtask

   task automatic test_random();
      int lat, wm, nr, bad = 0;
      logic err, w, sg, e;
      logic [1:0] sz;
      logic [31:0] a, wd, rd, exp_rd;
      for (int n = 0; n < 200; n++) begin
         w = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom); wd = $urandom;
         a = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 31));
         e = ref_err(sz, a);
         exp_rd = (!w && !e) ? ref_load(sz, sg, a) : 32'h0;
         issue(w, sz, sg, a, wd, lat, err, rd, wm, nr);
         if (w && !e) ref_store(sz, a, wd);
         n_tests++;
         if (lat != ref_lat(w, sz, a) || err !== e || rd !== exp_rd) begin
            n_fail++; bad++;
            if (bad < 10)
               $display("FAIL rnd_resp: w=%b sz=%0d a=%h lat=%0d err=%b rdata=%h required %0d %b %h",
                        w, sz, a, lat, err, rd, ref_lat(w, sz, a), e, exp_rd);
         end
         n_tests++;
         if ($countones(wm) != ((w && !e) ? 1 : 0) || nr != ((!e && (!w || sz != 2'd2)) ? 1 : 0)
             || dm_mem[ref_idx(a)] !== ref_mem[ref_idx(a)]) begin
            n_fail++; bad++;
            if (bad < 10)
               $display("FAIL rnd_mem: a=%h we_mask=%0h re=%0d word=%h required %h",
                        a, wm, nr, dm_mem[ref_idx(a)], ref_mem[ref_idx(a)]);
         end
      end
      n_tests++;
      if (mem_diffs() != 0) begin n_fail++; $display("FAIL rnd_final_mem: %0d words differ required 0", mem_diffs()); end
   endtask

   task automatic test_reset_mid();
      int rv = 0, c = 0;
      @(negedge clk);
      while (!req_ready && c < 20) begin @(negedge clk); c++; end
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h31; req_wdata = 32'h000000E7;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (dm_read_enable !== 1'b1) begin n_fail++; $display("FAIL mid_read: re=%b required 1", dm_read_enable); end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({req_ready, resp_valid, resp_err, dm_write_enable, dm_read_enable, dm_addr, dm_data_in, resp_rdata} !== '0) begin
         n_fail++;
         $display("FAIL mid_async: ready=%b rv=%b we=%b re=%b dm_addr=%h din=%h required all 0",
                  req_ready, resp_valid, dm_write_enable, dm_read_enable, dm_addr, dm_data_in);
      end
      @(posedge clk); @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 5; i++) begin @(negedge clk); if (resp_valid || dm_write_enable) rv++; end
      n_tests++;
      if (rv != 0 || dm_mem[12] !== ref_mem[12]) begin
         n_fail++; $display("FAIL mid_nowrite: events=%0d word=%h required 0 %h", rv, dm_mem[12], ref_mem[12]);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_sub_store();
      test_loads();
      test_errors();
      test_wrap();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
